// File: rtl/stopwatch_btn_ctrl_if.sv
// Button inputs and controller outputs of the stopwatch button controller.
// All signals are plain levels; no handshake, count_clr is a single-cycle strobe.
interface stopwatch_btn_ctrl_if;
  logic       btn_start;
  logic       btn_lap;
  logic       count_en;
  logic       count_clr;
  logic       disp_hold;
  logic [1:0] state;

  modport master (
    output btn_start,
    output btn_lap,
    input  count_en,
    input  count_clr,
    input  disp_hold,
    input  state
  );

  modport slave (
    input  btn_start,
    input  btn_lap,
    output count_en,
    output count_clr,
    output disp_hold,
    output state
  );
endinterface

// File: rtl/stopwatch_btn_ctrl.sv
// Stopwatch controller: per-button sync, debounce and one-pulse stages feeding a
// 4-state FSM (IDLE/RUN/PAUSE/LAP) that drives counter enable/clear and display hold.
module stopwatch_btn_ctrl #(
  parameter int DB_CYCLES = 100000,
  parameter int DB_W      = 17
) (
  input  logic                 clk,
  input  logic                 rst_n,
  stopwatch_btn_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_LAP   = 2'b11
  } state_e;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  // Bit 0 is the start/stop button, bit 1 is the lap/reset button.
  logic [1:0]      raw;
  logic [1:0]      s1_q;
  logic [1:0]      s2_q;
  logic [1:0]      db_q;
  logic [1:0]      db_d;
  logic [1:0]      db_dly_q;
  logic [1:0]      pulse_q;
  logic [1:0]      pulse_d;
  logic [DB_W-1:0] cnt_q [2];
  logic [DB_W-1:0] cnt_d [2];

  state_e state_q;
  state_e state_d;
  logic   count_en_q;
  logic   count_en_d;
  logic   count_clr_q;
  logic   count_clr_d;
  logic   disp_hold_q;
  logic   disp_hold_d;
  logic   p_start;
  logic   p_lap;

  assign raw = {bus.btn_lap, bus.btn_start};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= '0;
      s2_q     <= '0;
      db_q     <= '0;
      db_dly_q <= '0;
      pulse_q  <= '0;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q     <= raw;
      s2_q     <= s1_q;
      db_q     <= db_d;
      db_dly_q <= db_q;
      pulse_q  <= pulse_d;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // The counter only advances while the synced level disagrees with the debounced one,
  // so any glitch shorter than DB_CYCLES restarts it from zero.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          db_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Rising edge of the debounced level, registered: one cycle per press, none on release.
  assign pulse_d = db_q & ~db_dly_q;
  assign p_start = pulse_q[0];
  assign p_lap   = pulse_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      count_en_q  <= 1'b0;
      count_clr_q <= 1'b0;
      disp_hold_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_en_q  <= count_en_d;
      count_clr_q <= count_clr_d;
      disp_hold_q <= disp_hold_d;
    end
  end

  // Start has priority: a lap pulse in the same cycle is dropped.
  always_comb begin
    state_d = state_q;
    if (p_start) begin
      case (state_q)
        S_IDLE:  state_d = S_RUN;
        S_RUN:   state_d = S_PAUSE;
        S_PAUSE: state_d = S_RUN;
        S_LAP:   state_d = S_PAUSE;
        default: state_d = S_IDLE;
      endcase
    end else if (p_lap) begin
      case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_RUN:   state_d = S_LAP;
        S_PAUSE: state_d = S_IDLE;
        S_LAP:   state_d = S_RUN;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they register on the same edge as the state.
  always_comb begin
    count_en_d  = (state_d == S_RUN) || (state_d == S_LAP);
    disp_hold_d = (state_d == S_LAP);
    count_clr_d = (state_q == S_PAUSE) && (state_d == S_IDLE);
  end

  assign bus.state     = state_q;
  assign bus.count_en  = count_en_q;
  assign bus.count_clr = count_clr_q;
  assign bus.disp_hold = disp_hold_q;

endmodule
